pm_fetch_ctrl: RTL and testbench
================================

// Module: pm_fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the 32-entry program memory (PM).
//   - Owns the program counter and drives the PM address.
//   - Captures the combinational PM read into an instruction register.
//   - Issues each instruction to the execute stage over a valid/ready handshake.
//   - Applies jumps from the execute stage and stops on the HALT opcode.
// PARAMETERS
//   DATA_WIDTH   6          instruction width; must equal the PM data width
//   ADDR_WIDTH   5          PC/PM address width; the address space is 2**ADDR_WIDTH
//   RESET_PC     0          start address after reset and after restart from HALT
//   HALT_OPCODE  6'b111111  instruction that stops fetching
// PORTS
//   CLK       in   1           clock; all state updates on the rising edge
//   RST_N     in   1           asynchronous, active-low reset
//   START     in   1           begin/restart execution; sampled in IDLE and HALT only
//   PM_ADDR   out  ADDR_WIDTH  to PM_IN; always equals PC
//   PM_DATA   in   DATA_WIDTH  from PM_OUT; combinational read of PM_ADDR
//   IR        out  DATA_WIDTH  instruction register
//   IR_VALID  out  1           IR holds an instruction offered to the execute stage
//   IR_READY  in   1           execute stage accepts IR this cycle
//   JMP_EN    in   1           redirect the PC; valid only on the handshake cycle
//   JMP_ADDR  in   ADDR_WIDTH  jump target
//   PC        out  ADDR_WIDTH  program counter
//   BUSY      out  1           state is FETCH or ISSUE
//   HALTED    out  1           state is HALT
// BEHAVIOUR
//   - Reset (asynchronous, any state, mid-handshake included):
//     state=IDLE, PC=RESET_PC, IR=0, IR_VALID=0, BUSY=0, HALTED=0.
//   - IDLE: START=1 -> FETCH. Otherwise stay in IDLE.
//   - FETCH (1 cycle), IR<=PM_DATA:
//     - PM_DATA==HALT_OPCODE -> HALT. PC is not advanced. IR_VALID stays 0, so HALT is never issued.
//     - Otherwise -> ISSUE with IR_VALID<=1 and PC<=PC+1.
//     - PC increment is modulo 2**ADDR_WIDTH: 31 -> 0, with no flag.
//   - ISSUE: IR and IR_VALID are held stable until IR_VALID&&IR_READY.
//     - On the handshake cycle: IR_VALID<=0, next state FETCH.
//     - If JMP_EN=1 in the same cycle, PC<=JMP_ADDR, overriding the incremented PC.
//     - JMP_EN at any other time is ignored.
//   - HALT: HALTED=1.
//     - START=1 -> PC<=RESET_PC, HALTED<=0, go to FETCH.
//   - START in FETCH/ISSUE is ignored.
//   - Throughput: one instruction per 2 cycles when IR_READY is held high.
//     Latency from the START edge to the first IR_VALID is 2 edges.
//   - No combinational path from IR_READY/JMP_EN to any output; all outputs are registered or derived from state/PC.
// CONFIGURATION
//   - FETCH_STALL_CNT_EN defined:
//     - Adds output STALL_CNT [15:0] (out, 16): number of ISSUE cycles with IR_READY=0.
//     - Saturates at 16'hFFFF.
//     - Cleared by reset and by an accepted START.
//   - Not defined: no STALL_CNT port and no counter logic. All other behaviour is identical.
// TESTING
//   Bench PM image: 0:000000 1:111000 2:010110 3:101010 4:010101 5:111111, 6..31:101000.
//   1. Reset, START pulse, IR_READY=1 -> issues 000000,111000,010110,101010,010101,
//      one every 2 cycles; then HALTED=1, PC=5, IR=111111, IR_VALID=0.
//   2. Hold IR_READY=0 for 3 cycles at the first ISSUE -> IR=000000 and IR_VALID=1 held, PC=1;
//      with the macro, STALL_CNT=3.
//   3. At the handshake of addr 1, JMP_EN=1 JMP_ADDR=4 -> next issued 010101, then HALT with PC=5.
//   4. JMP_EN=1 JMP_ADDR=31 -> issues 101000 from addr 31, PC wraps to 0, next issued 000000.
//   5. Drop RST_N during ISSUE -> IR_VALID=0 immediately, PC=0, state IDLE;
//      no fetch occurs until START.
//   6. In HALT, pulse START -> HALTED=0, refetch from addr 0, first issued 000000.

Source files
------------

// File: rtl/pm_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pm_fetch_ctrl
//   Instruction-fetch sequencer for the 32-entry program memory.
//   Owns the program counter and drives the PM address. Captures the
//   combinational PM read into an instruction register. Offers each
//   instruction to the execute stage over a valid/ready handshake. Applies
//   jumps taken on the handshake cycle, and stops when it fetches the HALT
//   opcode.
//
//   Optional feature macro: FETCH_STALL_CNT_EN
//     When defined, adds output stall_cnt, a saturating count of ISSUE cycles
//     in which the execute stage was not ready. It is cleared by reset and by
//     an accepted start.
//
// Ports
//   clk       in   1           rising-edge clock
//   rst_n     in   1           asynchronous active-low reset
//   start     in   1           begin/restart execution (IDLE and HALT only)
//   pm_addr   out  ADDR_WIDTH  program memory address (always equals pc)
//   pm_data   in   DATA_WIDTH  combinational program memory read data
//   ir        out  DATA_WIDTH  instruction register
//   ir_valid  out  1           ir is offered to the execute stage
//   ir_ready  in   1           execute stage accepts ir this cycle
//   jmp_en    in   1           redirect pc (honoured only on the handshake cycle)
//   jmp_addr  in   ADDR_WIDTH  jump target
//   pc        out  ADDR_WIDTH  program counter
//   stall_cnt out  16          ISSUE cycles with ir_ready low (macro only)
//   busy      out  1           state is FETCH or ISSUE
//   halted    out  1           state is HALT
// -----------------------------------------------------------------------------
module pm_fetch_ctrl #(
  parameter int                    DATA_WIDTH  = 6,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  input  logic [DATA_WIDTH-1:0] pm_data,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jmp_en,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  output logic [ADDR_WIDTH-1:0] pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
  logic [DATA_WIDTH-1:0]   ir_r, ir_s;
  logic                    ir_valid_r, ir_valid_s;
  logic                    busy_r, busy_s;
  logic                    halted_r, halted_s;
  logic                    start_accept_s;

  // Next-state, pc, ir and handshake decode.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    ir_s           = ir_r;
    ir_valid_s     = ir_valid_r;
    start_accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s        = ST_FETCH;
          start_accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_s = pm_data;
        // HALT is captured into ir but never offered, and pc stays on it.
        if (pm_data == HALT_OPCODE) begin
          state_s    = ST_HALT;
          ir_valid_s = 1'b0;
        end else begin
          state_s    = ST_ISSUE;
          ir_valid_s = 1'b1;
          pc_s       = pc_r + PC_ONE;  // wraps modulo 2**ADDR_WIDTH
        end
      end
      ST_ISSUE: begin
        if (ir_valid_r && ir_ready) begin
          state_s    = ST_FETCH;
          ir_valid_s = 1'b0;
          // pc already points past this instruction; a jump replaces it.
          if (jmp_en) begin
            pc_s = jmp_addr;
          end else begin
            pc_s = pc_r;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_s        = ST_FETCH;
          pc_s           = RESET_PC;
          start_accept_s = 1'b1;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        pc_s       = RESET_PC;
        ir_valid_s = 1'b0;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with state_r.
  always_comb begin
    busy_s   = 1'b0;
    halted_s = 1'b0;
    case (state_s)
      ST_FETCH: busy_s   = 1'b1;
      ST_ISSUE: busy_s   = 1'b1;
      ST_HALT:  halted_s = 1'b1;
      default: begin
        busy_s   = 1'b0;
        halted_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, program counter, instruction register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      ir_r       <= {DATA_WIDTH{1'b0}};
      ir_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      ir_valid_r <= ir_valid_s;
      busy_r     <= busy_s;
      halted_r   <= halted_s;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_r, stall_cnt_s;

  // Saturating count of back-pressured ISSUE cycles; a new run starts from zero.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if (start_accept_s) begin
      stall_cnt_s = 16'h0000;
    end else if ((state_r == ST_ISSUE) && !ir_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_s = stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign pm_addr  = pc_r;
  assign pc       = pc_r;
  assign ir       = ir_r;
  assign ir_valid = ir_valid_r;
  assign busy     = busy_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_pm_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pm_fetch_ctrl
//   Self-checking bench for pm_fetch_ctrl. The program memory is modelled as
//   a combinational array. A vector table covers the straight-line run, the
//   restart from HALT, jumps, the pc wrap, and ignored jmp_en/start.
//   Hand-written sequences cover back-pressure, the stall counter (when
//   FETCH_STALL_CNT_EN is defined), and reset during ISSUE.
// -----------------------------------------------------------------------------
module tb_pm_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, ir_ready, jmp_en;
  logic [4:0] jmp_addr, pm_addr, pc;
  logic [5:0] pm_data, ir;
  logic       ir_valid, busy, halted;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [5:0] pm [32];
  assign pm_data = pm[pm_addr];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pm_fetch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pm_addr  (pm_addr),
    .pm_data  (pm_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .pc       (pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy     (busy),
    .halted   (halted)
  );

  typedef struct {
    logic       start;
    logic       ready;
    logic       jen;
    logic [4:0] jaddr;
    logic [5:0] ir;
    logic       vld;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] e_ir, input logic e_vld,
                         input logic [4:0] e_pc, input logic e_busy, input logic e_halt);
    chk({tag, ".ir"}, 32'(ir), 32'(e_ir));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_vld));
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".pm_addr"}, 32'(pm_addr), 32'(e_pc));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 5'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 5'd0;
    for (int i = 0; i < 32; i++) pm[i] = 6'b101000;
    pm[0] = 6'b000000; pm[1] = 6'b111000; pm[2] = 6'b010110;
    pm[3] = 6'b101010; pm[4] = 6'b010101; pm[5] = 6'b111111;

    //            start  rdy   jen   jaddr  ir          vld   pc     busy  halted
    // Straight-line run to HALT.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b0, 5'd0,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b1, 5'd1,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b111000, 1'b1, 5'd2,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b111000, 1'b0, 5'd2,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b010110, 1'b1, 5'd3,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b010110, 1'b0, 5'd3,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b101010, 1'b1, 5'd4,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b101010, 1'b0, 5'd4,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b010101, 1'b1, 5'd5,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b010101, 1'b0, 5'd5,  1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b111111, 1'b0, 5'd5,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b111111, 1'b0, 5'd5,  1'b0, 1'b1};
    // Restart from HALT.
    vecs[13] = '{1'b1, 1'b1, 1'b0, 5'd0,  6'b111111, 1'b0, 5'd0,  1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b1, 5'd1,  1'b1, 1'b0};
    // Jump at the handshake of addr 1 to addr 4.
    vecs[15] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b0, 5'd1,  1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b111000, 1'b1, 5'd2,  1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 5'd4,  6'b111000, 1'b0, 5'd4,  1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b010101, 1'b1, 5'd5,  1'b1, 1'b0};
    // Jump to 31, then wrap to 0.
    vecs[19] = '{1'b0, 1'b1, 1'b1, 5'd31, 6'b010101, 1'b0, 5'd31, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b101000, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b101000, 1'b0, 5'd0,  1'b1, 1'b0};
    // jmp_en and start during FETCH are ignored.
    vecs[22] = '{1'b1, 1'b1, 1'b1, 5'd20, 6'b000000, 1'b1, 5'd1,  1'b1, 1'b0};
    // jmp_en without handshake is ignored.
    vecs[23] = '{1'b1, 1'b0, 1'b1, 5'd9,  6'b000000, 1'b1, 5'd1,  1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 5'd0,  6'b000000, 1'b0, 5'd1,  1'b1, 1'b0};

    step();
    step();
    chk_all("reset", 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    chk_all("idle_hold", 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      start = vecs[i].start; ir_ready = vecs[i].ready;
      jmp_en = vecs[i].jen;  jmp_addr = vecs[i].jaddr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ir, vecs[i].vld, vecs[i].pc,
              vecs[i].busy, vecs[i].halted);
    end

    // Back-pressure at the first ISSUE.
    do_reset();
    start = 1'b1; ir_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    chk_all("stall_issue", 6'b000000, 1'b1, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 6'b000000, 1'b1, 5'd1, 1'b1, 1'b0);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
`endif
    ir_ready = 1'b1;
    step();
    chk_all("stall_accept", 6'b000000, 1'b0, 5'd1, 1'b1, 1'b0);
    begin : run_to_halt
      int budget;
      budget = 0;
      while (!halted && budget < 40) begin
        step();
        budget++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
    end
    chk_all("halt_state", 6'b111111, 1'b0, 5'd5, 1'b0, 1'b1);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt_kept", 32'(stall_cnt), 32'd3);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("restart", 6'b111111, 1'b0, 5'd0, 1'b1, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
`endif
    step();
    chk_all("restart_issue", 6'b000000, 1'b1, 5'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of ISSUE.
    ir_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0);
    end
    start = 1'b1; ir_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_all("post_rst_issue", 6'b000000, 1'b1, 5'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
